// File: rtl/instr_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : instr_encoder_if
//  Brief    : Request (field) channel and output (word) channel of the
//             streaming RV32 instruction encoder.
//  Revision : 1.0  initial release
// ============================================================================
interface instr_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic              in_itype;
    logic [3:0]        in_alu_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [11:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;

    // Loader / memory-writer side
    modport master (
        output in_valid, in_itype, in_alu_op, in_rd, in_rs1, in_rs2, in_imm,
        input  in_ready,
        input  out_valid, out_instr, out_addr,
        output out_ready
    );

    // Encoder side
    modport slave (
        input  in_valid, in_itype, in_alu_op, in_rd, in_rs1, in_rs2, in_imm,
        output in_ready,
        output out_valid, out_instr, out_addr,
        input  out_ready
    );
endinterface
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : instr_encoder
//  Brief    : Packs R-type / ADDI fields into RV32 words, tags each with a
//             sequential word address and emits through a 2-entry FIFO.
//             Optional macro ENCODER_ILLEGAL_NOP_EN: illegal requests emit a
//             NOP (addi x0,x0,0) instead of being dropped.
//  Revision : 1.0  initial release
// ============================================================================
module instr_encoder #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                err_clr,
    output logic                err,
    instr_encoder_if.slave      bus
);
    // ALU op codes shared with the decode stage: {funct7[5], funct3}
    localparam logic [3:0]        c_ALU_ADD = 4'b0000;
    localparam logic [3:0]        c_ALU_SUB = 4'b1000;
    localparam logic [3:0]        c_ALU_AND = 4'b0111;
    localparam logic [3:0]        c_ALU_OR  = 4'b0110;
    localparam logic [6:0]        c_OP_R    = 7'b0110011;
    localparam logic [6:0]        c_OP_I    = 7'b0010011;
    localparam logic [31:0]       c_NOP     = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] c_BASE    = ADDR_W'(BASE_ADDR);
`ifdef ENCODER_ILLEGAL_NOP_EN
    localparam logic              c_NOP_EN  = 1'b1;
`else
    localparam logic              c_NOP_EN  = 1'b0;
`endif

    logic [ADDR_W-1:0] r_count;
    logic [31:0]       r_fifo_instr [2];
    logic [ADDR_W-1:0] r_fifo_addr  [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_level;
    logic              r_err;

    logic              w_out_valid;
    logic              w_full;
    logic              w_pop;
    logic              w_accept;
    logic              w_push;
    logic              w_op_known;
    logic              w_legal;
    logic [2:0]        w_funct3;
    logic [6:0]        w_funct7;
    logic [31:0]       w_enc;
    logic [ADDR_W-1:0] w_tag;

    // Field decode and instruction packing
    always_comb begin
        w_funct3   = 3'b000;
        w_funct7   = 7'b0000000;
        w_op_known = 1'b1;
        case (bus.in_alu_op)
            c_ALU_ADD: w_funct3 = 3'b000;
            c_ALU_SUB: w_funct7 = 7'b0100000;
            c_ALU_AND: w_funct3 = 3'b111;
            c_ALU_OR:  w_funct3 = 3'b110;
            default:   w_op_known = 1'b0;
        endcase
        w_legal = w_op_known && (!bus.in_itype || (bus.in_alu_op == c_ALU_ADD));
        if (!w_legal)
            w_enc = c_NOP;
        else if (bus.in_itype)
            w_enc = {bus.in_imm, bus.in_rs1, 3'b000, bus.in_rd, c_OP_I};
        else
            w_enc = {w_funct7, bus.in_rs2, bus.in_rs1, w_funct3, bus.in_rd, c_OP_R};
    end

    // Handshake; a full buffer still accepts when the head is leaving this cycle
    always_comb begin
        w_out_valid   = (r_level != 2'd0);
        w_full        = (r_level == 2'd2);
        w_pop         = w_out_valid && bus.out_ready;
        bus.in_ready  = !w_full || bus.out_ready;
        w_accept      = bus.in_valid && bus.in_ready;
        w_push        = w_accept && (w_legal || c_NOP_EN);
        w_tag         = start ? c_BASE : r_count;
        bus.out_valid = w_out_valid;
        bus.out_instr = w_out_valid ? r_fifo_instr[r_rptr] : 32'h0;
        bus.out_addr  = w_out_valid ? r_fifo_addr[r_rptr]  : '0;
        err           = r_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= c_BASE;
        end else if (w_push) begin
            r_count <= w_tag + ADDR_W'(1);
        end else if (start) begin
            r_count <= c_BASE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_instr[i] <= 32'h0;
                r_fifo_addr[i]  <= '0;
            end
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_level <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_instr[r_wptr] <= w_enc;
                r_fifo_addr[r_wptr]  <= w_tag;
                r_wptr               <= ~r_wptr;
            end
            if (w_pop)
                r_rptr <= ~r_rptr;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 2'd1;
                2'b01:   r_level <= r_level - 2'd1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Setting wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_err <= 1'b0;
        else if (w_accept && !w_legal)
            r_err <= 1'b1;
        else if (err_clr)
            r_err <= 1'b0;
    end
endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_encoder
//  Brief    : Directed, table-driven bench for instr_encoder (ADDR_W = 2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_encoder;
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;
    localparam logic [3:0] ALU_AND = 4'b0111;
    localparam logic [3:0] ALU_OR  = 4'b0110;
    localparam logic [3:0] ALU_BAD = 4'b0001;

    typedef struct packed {
        logic        itype;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
        logic        legal;
        logic [31:0] instr;
    } vec_t;

    logic clk;
    logic rst_n;
    logic start;
    logic err_clr;
    logic err;
    int   n_checks;
    int   n_errors;
    vec_t vecs [10];
    logic [1:0] m_addr;
    logic [1:0] exp_wrap [5];

    instr_encoder_if #(.ADDR_W(2)) bus ();

    instr_encoder #(
        .ADDR_W    (2),
        .BASE_ADDR (0)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .err_clr (err_clr),
        .err     (err),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        bus.in_itype  = v.itype;
        bus.in_alu_op = v.op;
        bus.in_rd     = v.rd;
        bus.in_rs1    = v.rs1;
        bus.in_rs2    = v.rs2;
        bus.in_imm    = v.imm;
        bus.in_valid  = 1'b1;
    endtask

    task automatic do_reset;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        start         = 1'b0;
        err_clr       = 1'b0;
        step;
        step;
        rst_n = 1'b1;
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; start = 1'b0; err_clr = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.in_itype = 1'b0; bus.in_alu_op = 4'h0; bus.in_rd = 5'd0;
        bus.in_rs1 = 5'd0; bus.in_rs2 = 5'd0; bus.in_imm = 12'h0;
        n_checks = 0; n_errors = 0;

        //           itype op       rd     rs1    rs2    imm      legal instr
        vecs[0] = '{1'b0, ALU_ADD, 5'd3,  5'd1,  5'd2,  12'h000, 1'b1, 32'h002081B3};
        vecs[1] = '{1'b0, ALU_SUB, 5'd5,  5'd6,  5'd7,  12'h000, 1'b1, 32'h407302B3};
        vecs[2] = '{1'b1, ALU_ADD, 5'd1,  5'd0,  5'd0,  12'hFFF, 1'b1, 32'hFFF00093};
        vecs[3] = '{1'b0, ALU_AND, 5'd10, 5'd11, 5'd12, 12'h000, 1'b1, 32'h00C5F533};
        vecs[4] = '{1'b0, ALU_OR,  5'd31, 5'd31, 5'd31, 12'h000, 1'b1, 32'h01FFEFB3};
        vecs[5] = '{1'b0, ALU_BAD, 5'd4,  5'd4,  5'd4,  12'h000, 1'b0, 32'h00000013};
        vecs[6] = '{1'b1, ALU_OR,  5'd4,  5'd4,  5'd4,  12'h001, 1'b0, 32'h00000013};
        vecs[7] = '{1'b1, ALU_ADD, 5'd2,  5'd3,  5'd9,  12'h7FF, 1'b1, 32'h7FF18113};
        vecs[8] = '{1'b1, ALU_ADD, 5'd0,  5'd0,  5'd31, 12'h000, 1'b1, 32'h00000013};
        vecs[9] = '{1'b0, ALU_SUB, 5'd1,  5'd2,  5'd3,  12'h000, 1'b1, 32'h403100B3};
        exp_wrap = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        // Reset state, with a request offered while reset is held
        drive(vecs[0]);
        step;
        step;
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst out_instr", bus.out_instr, 32'd0);
        chk("rst out_addr", 32'(bus.out_addr), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        chk("rst in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        step;
        chk("post-rst out_valid", 32'(bus.out_valid), 32'd0);

        // Table: back-to-back streaming with out_ready high
        m_addr = 2'd0;
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i]);
            chk($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'd1);
            step;
            bus.in_valid = 1'b0;
            if (vecs[i].legal) begin
                chk($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'd1);
                chk($sformatf("vec%0d out_instr", i), bus.out_instr, vecs[i].instr);
                chk($sformatf("vec%0d out_addr", i), 32'(bus.out_addr), 32'(m_addr));
                chk($sformatf("vec%0d err", i), 32'(err), 32'd0);
                m_addr++;
            end else begin
                chk($sformatf("vec%0d err set", i), 32'(err), 32'd1);
`ifdef ENCODER_ILLEGAL_NOP_EN
                chk($sformatf("vec%0d nop valid", i), 32'(bus.out_valid), 32'd1);
                chk($sformatf("vec%0d nop instr", i), bus.out_instr, 32'h00000013);
                chk($sformatf("vec%0d nop addr", i), 32'(bus.out_addr), 32'(m_addr));
                m_addr++;
`else
                chk($sformatf("vec%0d dropped", i), 32'(bus.out_valid), 32'd0);
`endif
                err_clr = 1'b1;
                step;
                err_clr = 1'b0;
                chk($sformatf("vec%0d err cleared", i), 32'(err), 32'd0);
            end
        end
        step;
        chk("table drained", 32'(bus.out_valid), 32'd0);

        // Backpressure: two accepted, third stalls, then all emitted in order
        do_reset;
        bus.out_ready = 1'b0;
        drive(vecs[0]);
        step;
        chk("bp first visible", bus.out_instr, vecs[0].instr);
        drive(vecs[1]);
        chk("bp second in_ready", 32'(bus.in_ready), 32'd1);
        step;
        drive(vecs[2]);
        chk("bp full in_ready", 32'(bus.in_ready), 32'd0);
        step;
        chk("bp still full", 32'(bus.in_ready), 32'd0);
        chk("bp head held", bus.out_instr, vecs[0].instr);
        chk("bp head addr", 32'(bus.out_addr), 32'd0);
        bus.out_ready = 1'b1;
        #1;
        chk("bp in_ready via out_ready", 32'(bus.in_ready), 32'd1);
        step;
        bus.in_valid = 1'b0;
        chk("bp word1 instr", bus.out_instr, vecs[1].instr);
        chk("bp word1 addr", 32'(bus.out_addr), 32'd1);
        step;
        chk("bp word2 instr", bus.out_instr, vecs[2].instr);
        chk("bp word2 addr", 32'(bus.out_addr), 32'd2);
        step;
        chk("bp no duplicate", 32'(bus.out_valid), 32'd0);

        // Address wrap at 2^ADDR_W, then start
        do_reset;
        for (int k = 0; k < 5; k++) begin
            drive(vecs[k]);
            step;
            chk($sformatf("wrap%0d addr", k), 32'(bus.out_addr), 32'(exp_wrap[k]));
        end
        drive(vecs[7]);
        start = 1'b1;
        step;
        start = 1'b0;
        chk("start tag", 32'(bus.out_addr), 32'd0);
        chk("start instr", bus.out_instr, vecs[7].instr);
        drive(vecs[8]);
        step;
        chk("after start tag", 32'(bus.out_addr), 32'd1);
        bus.in_valid = 1'b0;
        start = 1'b1;
        step;
        start = 1'b0;
        drive(vecs[9]);
        step;
        bus.in_valid = 1'b0;
        chk("lone start reload", 32'(bus.out_addr), 32'd0);
        step;

        // err set beats same-cycle err_clr
        drive(vecs[6]);
        err_clr = 1'b1;
        step;
        bus.in_valid = 1'b0;
        chk("err priority", 32'(err), 32'd1);
        step;
        err_clr = 1'b0;
        chk("err clear", 32'(err), 32'd0);
        step;

        // Asynchronous reset with two words buffered
        bus.out_ready = 1'b0;
        drive(vecs[0]);
        step;
        drive(vecs[1]);
        step;
        bus.in_valid = 1'b0;
        chk("pre-areset valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset out_valid", 32'(bus.out_valid), 32'd0);
        chk("areset in_ready", 32'(bus.in_ready), 32'd1);
        step;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        drive(vecs[3]);
        step;
        bus.in_valid = 1'b0;
        chk("post-areset instr", bus.out_instr, vecs[3].instr);
        chk("post-areset addr", 32'(bus.out_addr), 32'd0);
        step;
        chk("post-areset drained", 32'(bus.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
